// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing block: op codes, flag bit positions,
// controller state encoding and the op-support check.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Codes 100, 110 and 111 have no ALU meaning; they still execute but are flagged.
  function automatic logic op_unsupported(input logic [2:0] op);
    logic bad;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: bad = 1'b0;
      default:                               bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on the last served port, or fixed priority to
// port 0. The pointer only moves when a response is accepted.
module rr_arb2 #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);

  logic last_r;

  // Last served port; resetting to 1 gives port 0 the first contested grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= 1'b1;
    end else if (upd) begin
      last_r <= upd_id;
    end
  end

  // Grant vector, one-hot or zero.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (RR_EN != 0) begin
          grant = last_r ? 2'b01 : 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between the execute datapath (port 0)
// and the branch/address-compare unit (port 1); one transaction in flight.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  output logic             busy
);

  logic [1:0] state_r;
  logic       id_r;
  logic [1:0] grant;
  logic       req_hs;
  logic       rsp_hs;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .upd    (rsp_hs),
    .upd_id (id_r),
    .grant  (grant)
  );

  // Grants are only offered from IDLE and never while reset is applied.
  assign req_ready = ((state_r == ST_IDLE) && rst) ? grant : 2'b00;
  assign req_hs    = |(req_valid & req_ready);
  assign rsp_hs    = (state_r == ST_RESP) && rsp_ready[id_r];
  assign busy      = (state_r != ST_IDLE);

  // Controller: latch operands, capture ALU result, hold response until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      id_r      <= 1'b0;
      alu_a     <= {WIDTH{1'b0}};
      alu_b     <= {WIDTH{1'b0}};
      alu_ctrl  <= 3'b000;
      rsp_valid <= 2'b00;
      rsp_res   <= {WIDTH{1'b0}};
      rsp_flags <= 4'b0000;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_hs) begin
            id_r     <= grant[1];
            alu_a    <= grant[1] ? req_a1  : req_a0;
            alu_b    <= grant[1] ? req_b1  : req_b0;
            alu_ctrl <= grant[1] ? req_op1 : req_op0;
            state_r  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_res           <= alu_res;
          rsp_flags[FLAG_N] <= alu_n;
          rsp_flags[FLAG_Z] <= alu_z;
          rsp_flags[FLAG_V] <= alu_v;
          rsp_flags[FLAG_C] <= alu_c;
          rsp_err           <= op_unsupported(alu_ctrl);
          rsp_valid         <= id_r ? 2'b10 : 2'b01;
          state_r           <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            rsp_valid <= 2'b00;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance share
// stimulus; each sees its own behavioural ALU. Directed steps then random traffic.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;

  logic [1:0]  rr_req_ready, rr_rsp_valid, fp_req_ready, fp_rsp_valid;
  logic [31:0] rr_rsp_res, fp_rsp_res, rr_alu_a, rr_alu_b, fp_alu_a, fp_alu_b;
  logic [3:0]  rr_rsp_flags, fp_rsp_flags;
  logic        rr_rsp_err, fp_rsp_err, rr_busy, fp_busy;
  logic [2:0]  rr_alu_ctrl, fp_alu_ctrl;
  logic [35:0] rr_alu, fp_alu;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic last_g;

  always #5 clk = ~clk;

  // ALU behaviour: returns {N,Z,V,C,result}. C is carry (add) / no-borrow (sub).
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic v, c;
    v = 1'b0; c = 1'b0; r = 32'd0; s = 33'd0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                    v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = ~s[32];
                    v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), v, c, r};
  endfunction

  assign rr_alu = alu_ref(rr_alu_a, rr_alu_b, rr_alu_ctrl);
  assign fp_alu = alu_ref(fp_alu_a, fp_alu_b, fp_alu_ctrl);

  alu_share_arb #(.WIDTH(32), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rr_rsp_res), .rsp_flags(rr_rsp_flags), .rsp_err(rr_rsp_err),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_ctrl(rr_alu_ctrl), .alu_res(rr_alu[31:0]),
    .alu_n(rr_alu[35]), .alu_z(rr_alu[34]), .alu_v(rr_alu[33]), .alu_c(rr_alu[32]),
    .busy(rr_busy)
  );

  alu_share_arb #(.WIDTH(32), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(fp_rsp_res), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_ctrl(fp_alu_ctrl), .alu_res(fp_alu[31:0]),
    .alu_n(fp_alu[35]), .alu_z(fp_alu[34]), .alu_v(fp_alu[33]), .alu_c(fp_alu[32]),
    .busy(fp_busy)
  );

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (p == 1) begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid[1] = 1'b1;
    end else begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid[0] = 1'b1;
    end
  endtask

  task automatic chk_rsp(input string tag, input int p, input logic [31:0] er,
                         input logic [3:0] ef, input logic ee);
    chk({tag, "_valid"}, rr_rsp_valid, oh(p));
    chk({tag, "_res"},   rr_rsp_res,   er);
    chk({tag, "_flags"}, rr_rsp_flags, ef);
    chk({tag, "_err"},   rr_rsp_err,   ee);
  endtask

  // One request on port p issued from IDLE, response held for 'stall' extra cycles.
  task automatic txn(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] op, input int stall, input logic [31:0] er,
                     input logic [3:0] ef, input logic ee);
    drive(p, a, b, op);
    #1;
    chk({tag, "_grant"}, rr_req_ready, oh(p));
    @(negedge clk);
    req_valid[p] = 1'b0;
    chk({tag, "_exec_busy"},  rr_busy, 1'b1);
    chk({tag, "_exec_valid"}, rr_rsp_valid, 2'b00);
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      chk_rsp({tag, "_stall"}, p, er, ef, ee);
      @(negedge clk);
    end
    chk_rsp(tag, p, er, ef, ee);
    rsp_ready = oh(p);
    @(negedge clk);
    chk({tag, "_clear"}, rr_rsp_valid, 2'b00);
    rsp_ready = 2'b00;
    last_g = (p == 1);
  endtask

  logic [1:0]  g;
  logic [35:0] ex;
  logic        ee;
  bit          pend [2];
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [2:0]  pop [2];
  int          gp, stall;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    req_op0 = 3'b000; req_op1 = 3'b000; last_g = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", rr_req_ready, 2'b00);
    chk("rst_rsp_valid", rr_rsp_valid, 2'b00);
    chk("rst_rsp_res",   rr_rsp_res,   32'd0);
    chk("rst_rsp_flags", rr_rsp_flags, 4'd0);
    chk("rst_rsp_err",   rr_rsp_err,   1'b0);
    chk("rst_alu_a",     rr_alu_a,     32'd0);
    chk("rst_alu_ctrl",  rr_alu_ctrl,  3'b000);
    chk("rst_busy",      rr_busy,      1'b0);
    chk("rst_fp_busy",   fp_busy,      1'b0);
    rst = 1'b1;

    // Asynchronous reset while port 0 waits in RESP
    @(negedge clk);
    drive(0, 32'h1234_5678, 32'h0000_0008, OP_SUB);
    #1 chk("rmid_grant", rr_req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rmid_pre_valid", rr_rsp_valid, 2'b01);
    chk("rmid_pre_ctrl",  rr_alu_ctrl,  3'b001);
    #2 rst = 1'b0;
    #1;
    chk("rmid_valid", rr_rsp_valid, 2'b00);
    chk("rmid_busy",  rr_busy,      1'b0);
    chk("rmid_ctrl",  rr_alu_ctrl,  3'b000);
    chk("rmid_alu_a", rr_alu_a,     32'd0);
    chk("rmid_res",   rr_rsp_res,   32'd0);
    @(negedge clk);
    rst = 1'b1; last_g = 1'b1;
    txn("rmid_p1", 1, 32'd40, 32'd2, OP_ADD, 0, 32'd42, 4'b0000, 1'b0);

    // Directed ALU cases
    txn("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 0, 32'h8000_0000, 4'b1010, 1'b0);
    txn("sub_stall", 1, 32'd5, 32'd5, OP_SUB, 4, 32'd0, 4'b0101, 1'b0);
    txn("slt_neg", 0, 32'hFFFF_FFFF, 32'd1, OP_SLT, 0, 32'd1, 4'b0000, 1'b0);
    txn("op110", 0, 32'hDEAD_BEEF, 32'h1234_5678, 3'b110, 0, 32'd0, 4'b0100, 1'b1);

    // Port 1 requests while port 0 is in flight
    drive(0, 32'hF0F0_0000, 32'h0000_0F0F, OP_OR);
    #1 chk("busy_grant0", rr_req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive(1, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND);
    #1 chk("busy_rdy_exec", rr_req_ready, 2'b00);
    @(negedge clk);
    chk("busy_rdy_resp", rr_req_ready, 2'b00);
    chk_rsp("busy_p0", 0, 32'hF0F0_0F0F, 4'b1000, 1'b0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00; last_g = 1'b0;
    chk("busy_p0_clear", rr_rsp_valid, 2'b00);
    txn("busy_p1", 1, 32'hFF00_FF00, 32'h0FF0_0FF0, OP_AND, 0, 32'h0F00_0F00, 4'b0000, 1'b0);

    // Both ports continuously valid, responses always accepted
    rsp_ready = 2'b11;
    drive(0, 32'd10, 32'd20, OP_ADD);
    drive(1, 32'd100, 32'd1, OP_SUB);
    for (int k = 0; k < 6; k++) begin
      g = last_g ? 2'b01 : 2'b10;
      #1;
      chk("fair_grant", rr_req_ready, g);
      chk("fixed_grant", fp_req_ready, 2'b01);
      @(negedge clk);
      chk("fair_exec_rdy", rr_req_ready, 2'b00);
      @(negedge clk);
      chk("fair_rsp_valid", rr_rsp_valid, g);
      chk("fair_rsp_res", rr_rsp_res, g[1] ? 32'd99 : 32'd30);
      chk("fixed_rsp_valid", fp_rsp_valid, 2'b01);
      chk("fixed_rsp_res", fp_rsp_res, 32'd30);
      @(negedge clk);
      last_g = g[1];
    end
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Random traffic against a pending-request model
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1; pa[p] = $urandom; pb[p] = $urandom; pop[p] = 3'($urandom_range(0, 7));
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[1] = 1'b1; pa[1] = $urandom; pb[1] = $urandom; pop[1] = 3'($urandom_range(0, 7));
      end
      if (pend[0]) drive(0, pa[0], pb[0], pop[0]);
      else begin req_valid[0] = 1'b0; req_a0 = $urandom; end
      if (pend[1]) drive(1, pa[1], pb[1], pop[1]);
      else begin req_valid[1] = 1'b0; req_b1 = $urandom; end
      gp = (pend[0] && pend[1]) ? (last_g ? 0 : 1) : (pend[1] ? 1 : 0);
      ex = alu_ref(pa[gp], pb[gp], pop[gp]);
      ee = (pop[gp] == 3'b100) || (pop[gp] == 3'b110) || (pop[gp] == 3'b111);
      #1 chk("rnd_grant", rr_req_ready, oh(gp));
      @(negedge clk);
      pend[gp] = 1'b0; req_valid[gp] = 1'b0;
      chk("rnd_exec_valid", rr_rsp_valid, 2'b00);
      @(negedge clk);
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        chk_rsp("rnd_stall", gp, ex[31:0], ex[35:32], ee);
        rsp_ready = ($urandom_range(0, 1) == 1) ? ~oh(gp) : 2'b00;
        @(negedge clk);
      end
      chk_rsp("rnd", gp, ex[31:0], ex[35:32], ee);
      rsp_ready = oh(gp) | (($urandom_range(0, 1) == 1) ? ~oh(gp) : 2'b00);
      @(negedge clk);
      chk("rnd_clear", rr_rsp_valid, 2'b00);
      rsp_ready = 2'b00;
      last_g = gp[0];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational 32-bit ALU between two requesters.
- Port 0 is the execute-stage datapath; port 1 is the branch/address-compare unit.
- Arbitrates requests, registers operands onto the ALU, captures result and N/Z/V/C flags, and returns them to the granted requester over a valid/ready response channel.
- Sits between the requesters and the ALU instance, which stays outside this block.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU.
- RR_EN, 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 winning.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port request ready.
- req_a0, req_b0  in  WIDTH each  port 0 operands.
- req_a1, req_b1  in  WIDTH each  port 1 operands.
- req_op0, req_op1  in  3 each  ALU control code per port.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_res  out  WIDTH  result, shared by both ports; meaningful only where rsp_valid is set.
- rsp_flags  out  4  {N,Z,V,C}.
- rsp_err  out  1  the served op code is unsupported.
- alu_a, alu_b  out  WIDTH each  to ALU operand inputs.
- alu_ctrl  out  3  to ALU control input.
- alu_res  in  WIDTH  from ALU result.
- alu_n, alu_z, alu_v, alu_c  in  1 each  from ALU flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, any time, mid-operation included):
  - State goes to IDLE; any in-flight transaction is dropped silently.
  - req_ready=0 (driven from state, IDLE only), rsp_valid=0, rsp_res=0, rsp_flags=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_ctrl=3'b000, busy=0.
  - Round-robin pointer resets so port 0 has priority first.
- States: IDLE -> EXEC -> RESP -> IDLE. Exactly one transaction outstanding.
- IDLE:
  - req_ready = grant vector, one-hot or zero, computed combinationally from req_valid and the pointer.
  - With both ports valid: round-robin grants the port not granted last; fixed priority grants port 0.
  - On handshake at cycle t: latch port id, operands into alu_a/alu_b, and op into alu_ctrl; go to EXEC.
- EXEC (cycle t+1):
  - ALU sees stable registered inputs.
  - At the end of the cycle: capture alu_res into rsp_res and {alu_n,alu_z,alu_v,alu_c} into rsp_flags.
  - Set rsp_err = (op is 3'b100, 3'b110 or 3'b111).
  - Go to RESP.
- RESP (from cycle t+2):
  - rsp_valid[id]=1; the other bit stays 0.
  - rsp_res, rsp_flags and rsp_err stay stable until the handshake.
  - On rsp_ready[id]: clear rsp_valid, update the round-robin pointer to id, go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Latency and throughput:
  - Request handshake to rsp_valid is 2 cycles.
  - Best-case issue interval is 3 cycles, since IDLE is re-entered before the next grant.
- Request rules:
  - req_ready stays 0 in EXEC and RESP.
  - A requester holds req_valid and its operands until its handshake.
  - The block never drops a request that has not been granted.
- Boundaries:
  - req_valid changing while not granted has no effect.
  - rsp_ready held high permanently gives the 3-cycle issue interval.
  - rsp_ready held low stalls the block indefinitely in RESP with outputs frozen.
  - No starvation under RR_EN=1: with both ports continuously valid, grants alternate 0,1,0,1.
- Flags pass through exactly as the ALU computes them. The ALU defines C as masked for logic ops and V as valid only for add/sub. The block does no recomputation.
- Unsupported ops (100, 110, 111) still execute. The ALU returns 0, so Z=1, and rsp_err=1.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - Flag bit indices: N=3, Z=2, V=1, C=0.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed grant with pointer update input.

Test Plan:
- Reset mid-RESP: port 0 in flight, assert rst=0 asynchronously -> rsp_valid=2'b00, busy=0, alu_ctrl=000 immediately; after release, a port-1 request is served normally.
- Port 0 ADD, a=0x7FFFFFFF, b=1 -> 2 cycles later rsp_valid=2'b01, rsp_res=0x80000000, flags N=1 Z=0 V=1 C=0.
- Port 1 SUB, a=5, b=5, rsp_ready held low 4 cycles -> rsp_valid=2'b10 stable throughout, rsp_res=0, Z=1, C=1; clears the cycle after rsp_ready[1]=1.
- Both ports continuously valid, RR_EN=1, rsp_ready=2'b11 -> grant order 0,1,0,1, one grant every 3 cycles. Repeat with RR_EN=0 -> port 0 granted every time.
- Port 0 SLT, a=0xFFFFFFFF, b=1 -> rsp_res=1, rsp_err=0. Port 0 op=3'b110 -> rsp_res=0, Z=1, rsp_err=1.
- Request on port 1 while busy -> req_ready[1]=0 until IDLE; operands unchanged; served next with the correct result.
